// File: rtl/div_dispatch.sv
// div_dispatch
// Feeds the shift-divider from a small FIFO of (dividend, divisor) pairs. Each
// pair is popped in IDLE, held on xD_o/yD_o for the whole operation and
// started with a one-cycle div_start pulse. The quotient is returned downstream
// over a valid/ready handshake. A zero divisor is trapped here and answered with
// an error, without starting the divider. If the divider does not answer within
// TIMEOUT WAIT cycles, the operation is abandoned with an error.
//
// Ports
//   c           clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    operand pair offered             in_ready   FIFO not full (registered count)
//   in_x/in_y   dividend / divisor
//   xD_o/yD_o   operands to the divider, held for the whole operation
//   div_start   one-cycle start pulse to the divider
//   div_done    divider finished, div_z valid    div_z      divider quotient
//   out_valid   result available                 out_ready  consumer accepts result
//   out_z       quotient (0 on error)            out_err    zero divisor or timeout
module div_dispatch #(
  parameter int W       = 6,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic         c,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  output logic [W-1:0] xD_o,
  output logic [W-1:0] yD_o,
  output logic         div_start,
  input  logic         div_done,
  input  logic [W-1:0] div_z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_z,
  output logic         out_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] FULL    = CNTW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [W-1:0]    xd_q, xd_d;
  logic [W-1:0]    yd_q, yd_d;
  logic [W-1:0]    z_q, z_d;
  logic            err_q, err_d;

  // Operand storage: {dividend, divisor} per entry. The head is read
  // combinationally so it can be latched in the same cycle it is popped.
  logic [2*W-1:0]  mem_q [DEPTH];
  logic [W-1:0]    head_x, head_y;
  logic            push, pop;

  // in_ready comes from the registered count only, so a pop on a full FIFO
  // does not reopen the input in that same cycle.
  assign in_ready  = (count_q != FULL);
  assign push      = in_valid && in_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign head_x    = mem_q[rd_ptr_q][2*W-1:W];
  assign head_y    = mem_q[rd_ptr_q][W-1:0];

  assign xD_o      = xd_q;
  assign yD_o      = yd_q;
  assign div_start = (state_q == ISSUE);
  assign out_valid = (state_q == RESP);
  assign out_z     = z_q;
  assign out_err   = err_q;

  always_ff @(posedge c) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_x, in_y};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CNTW'(push) - CNTW'(pop);
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    xd_d    = xd_q;
    yd_d    = yd_q;
    z_d     = z_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          xd_d = head_x;
          yd_d = head_y;
          if (head_y == '0) begin
            // Zero divisor never reaches the divider.
            z_d     = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // div_done is checked first so it wins over a coincident timeout.
        if (div_done) begin
          z_d     = div_z;
          err_d   = 1'b0;
          wcnt_d  = '0;
          state_d = RESP;
        end else if (wcnt_q == TO_LAST) begin
          z_d     = '0;
          err_d   = 1'b1;
          wcnt_d  = '0;
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wcnt_q   <= '0;
      xd_q     <= '0;
      yd_q     <= '0;
      z_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wcnt_q   <= wcnt_d;
      xd_q     <= xd_d;
      yd_q     <= yd_d;
      z_q      <= z_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_div_dispatch.sv
// tb_div_dispatch
// Directed bench for div_dispatch: drives operand pairs and divider responses
// by hand and compares against hand-computed values through chk().
module tb_div_dispatch;
  localparam int W       = 6;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic         c = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x, in_y;
  logic [W-1:0] xD_o, yD_o;
  logic         div_start;
  logic         div_done;
  logic [W-1:0] div_z;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_z;
  logic         out_err;

  int n_cmp  = 0;
  int n_bad  = 0;
  int starts = 0;

  div_dispatch #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .c(c), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .xD_o(xD_o), .yD_o(yD_o), .div_start(div_start),
    .div_done(div_done), .div_z(div_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_err(out_err)
  );

  always #5 c = ~c;

  always @(negedge c) if (div_start) starts++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; a pending push that the edge accepted is withdrawn.
  task automatic tick();
    logic acc;
    acc = in_valid && in_ready;
    @(posedge c);
    #1;
    if (acc) in_valid = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
    in_x = x; in_y = y; in_valid = 1'b1;
    for (int i = 0; i < 60 && in_valid; i++) tick();
    chk("push_accept", in_valid, 0);
    in_valid = 1'b0;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 60 && !div_start; i++) tick();
    chk("start_seen", div_start, 1);
  endtask

  task automatic accept();
    $display("result z=%0d err=%0d", out_z, out_err);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
  endtask

  // Called in WAIT: answer after 'delay' more cycles, hold RESP 'hold' cycles.
  task automatic finish(input logic [W-1:0] x, input logic [W-1:0] z, input int delay, input int hold);
    repeat (delay) tick();
    div_done = 1'b1; div_z = z;
    tick();
    div_done = 1'b0;
    chk("resp_valid", out_valid, 1);
    chk("out_z", out_z, z);
    chk("out_err", out_err, 0);
    chk("xD_held", xD_o, x);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_z", out_z, z);
    end
    accept();
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                        input int delay, input int hold);
    wait_start();
    chk("xD", xD_o, x);
    chk("yD", yD_o, y);
    tick();
    chk("start_pulse_one", div_start, 0);
    finish(x, z, delay, hold);
  endtask

  logic [W-1:0] xs5 [4] = '{6'd33, 6'd44, 6'd55, 6'd60};
  logic [W-1:0] ys5 [4] = '{6'd11, 6'd4,  6'd5,  6'd12};
  logic [W-1:0] zs5 [4] = '{6'd3,  6'd11, 6'd11, 6'd5};

  initial begin
    int s0, k;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0;
    div_done = 1'b0; div_z = '0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_xD", xD_o, 0);
    chk("rst_yD", yD_o, 0);
    chk("rst_start", div_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_err", out_err, 0);
    repeat (2) @(posedge c);
    #2 rst_n = 1'b1;
    tick();

    // 1: basic op, done two cycles after start, plus empty-FIFO latency
    s0 = starts;
    push(6'd12, 6'd4);
    chk("t1_no_start_early", div_start, 0);
    tick();
    chk("t1_start_latency", div_start, 1);
    run_op(6'd12, 6'd4, 6'd3, 1, 0);
    chk("t1_one_start", starts - s0, 1);

    // 2: zero divisor trapped, next entry proceeds (done in first WAIT cycle)
    s0 = starts;
    push(6'd9, 6'd0);
    push(6'd20, 6'd5);
    chk("t2_err_valid", out_valid, 1);
    chk("t2_err_z", out_z, 0);
    chk("t2_err_flag", out_err, 1);
    chk("t2_yD_zero", yD_o, 0);
    chk("t2_no_start", starts - s0, 0);
    accept();
    run_op(6'd20, 6'd5, 6'd4, 0, 0);
    chk("t2_one_start", starts - s0, 1);

    // 3: stalled divider, FIFO fills to DEPTH, fifth pair held off
    push(6'd40, 6'd5);
    wait_start();
    tick();
    push(6'd63, 6'd7);
    push(6'd30, 6'd6);
    push(6'd17, 6'd3);
    push(6'd50, 6'd10);
    chk("t3_full", in_ready, 0);
    in_x = 6'd51; in_y = 6'd3; in_valid = 1'b1;
    repeat (3) tick();
    chk("t3_holdoff", in_valid, 1);
    chk("t3_still_full", in_ready, 0);
    finish(6'd40, 6'd8, 0, 0);
    run_op(6'd63, 6'd7, 6'd9, 2, 0);
    chk("t3_fifth_taken", in_valid, 0);
    run_op(6'd30, 6'd6, 6'd5, 0, 0);
    run_op(6'd17, 6'd3, 6'd5, 3, 0);
    run_op(6'd50, 6'd10, 6'd5, 1, 0);
    run_op(6'd51, 6'd3, 6'd17, 0, 0);

    // 4: timeout, late div_done ignored
    push(6'd8, 6'd2);
    wait_start();
    k = 0;
    tick(); k++;
    while (!out_valid && k < 40) begin tick(); k++; end
    chk("t4_timeout_cycles", k, TIMEOUT + 1);
    chk("t4_err", out_err, 1);
    chk("t4_z", out_z, 0);
    div_done = 1'b1; div_z = 6'd33;
    tick();
    div_done = 1'b0;
    chk("t4_resp_ignores_done_z", out_z, 0);
    chk("t4_resp_ignores_done_err", out_err, 1);
    accept();
    s0 = starts;
    div_done = 1'b1; div_z = 6'd7;
    tick();
    div_done = 1'b0;
    tick();
    chk("t4_idle_ignores_done", out_valid, 0);
    chk("t4_idle_no_start", starts - s0, 0);

    // 5: consumer stalls 10 cycles, FIFO keeps filling
    push(6'd21, 6'd7);
    wait_start();
    tick();
    div_done = 1'b1; div_z = 6'd3;
    tick();
    div_done = 1'b0;
    s0 = starts;
    for (int i = 0; i < 10; i++) begin
      if (!in_valid && i < 4) begin in_x = xs5[i]; in_y = ys5[i]; in_valid = 1'b1; end
      tick();
      chk("t5_valid", out_valid, 1);
      chk("t5_z", out_z, 3);
      chk("t5_err", out_err, 0);
      chk("t5_no_start", div_start, 0);
    end
    chk("t5_fifo_full", in_ready, 0);
    chk("t5_no_new_start", starts - s0, 0);
    accept();
    for (int i = 0; i < 4; i++) run_op(xs5[i], ys5[i], zs5[i], i, 0);

    // 6: asynchronous reset during WAIT with 3 entries queued
    push(6'd10, 6'd2);
    wait_start();
    tick();
    push(6'd1, 6'd1);
    push(6'd2, 6'd1);
    push(6'd3, 6'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_xD", xD_o, 0);
    chk("t6_yD", yD_o, 0);
    chk("t6_out_z", out_z, 0);
    chk("t6_out_err", out_err, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    @(posedge c);
    #2 rst_n = 1'b1;
    s0 = starts;
    repeat (6) tick();
    chk("t6_post_in_ready", in_ready, 1);
    chk("t6_post_no_start", starts - s0, 0);
    chk("t6_post_valid", out_valid, 0);
    chk("t6_post_xD", xD_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
